// File: rtl/apb3_master_arbiter_if.sv
// Bundle of requester-side and APB-side signals for the round-robin APB3 master arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding system.
interface apb3_master_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*32-1:0]         req_wdata;
    logic [NUM_REQ-1:0]            done;
    logic [31:0]                   rdata;
    logic                          err;
    logic                          busy;
    logic [3:0]                    gnt_id;
    logic                          psel;
    logic                          penable;
    logic                          pwrite;
    logic [ADDR_WIDTH-1:0]         paddr;
    logic [31:0]                   pwdata;
    logic                          pready;
    logic [31:0]                   prdata;
    logic                          pslverr;

    modport master (
        input  req, req_write, req_addr, req_wdata, pready, prdata, pslverr,
        output done, rdata, err, busy, gnt_id, psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req, req_write, req_addr, req_wdata, pready, prdata, pslverr,
        input  done, rdata, err, busy, gnt_id, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb3_master_arbiter.sv
// Round-robin arbiter sharing one APB3 master port among NUM_REQ requesters.
// Sequences SETUP/ACCESS, returns the response to the winner and aborts stalled transfers.
module apb3_master_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  pclk,
    input  logic                  preset,
    apb3_master_arbiter_if.master bus
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);
    localparam logic [3:0] LAST_IDX = 4'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                state_r;
    logic [3:0]            ptr_r;
    logic [3:0]            gnt_id_r;
    logic [CNT_W-1:0]      wait_cnt_r;
    logic [NUM_REQ-1:0]    done_r;
    logic [31:0]           rdata_r;
    logic                  err_r;
    logic                  busy_r;
    logic                  psel_r;
    logic                  penable_r;
    logic                  pwrite_r;
    logic [ADDR_WIDTH-1:0] paddr_r;
    logic [31:0]           pwdata_r;

    logic [NUM_REQ-1:0]    eligible_s;
    logic [NUM_REQ-1:0]    hi_mask_s;
    logic [4:0]            pick_hi_s;
    logic [4:0]            pick_lo_s;
    logic                  found_s;
    logic [3:0]            winner_s;
    logic [3:0]            ptr_nxt_s;
    logic [CNT_W-1:0]      wait_nxt_s;
    logic                  sel_write_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [31:0]           sel_wdata_s;

    // Lowest set bit of vec as {found, index}
    function automatic logic [4:0] lowest_set(input logic [NUM_REQ-1:0] vec);
        logic [4:0] res;
        res = 5'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            res = vec[i] ? {1'b1, 4'(i)} : res;
        end
        return res;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [3:0] idx);
        logic [NUM_REQ-1:0] res;
        res = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            res[i] = (4'(i) == idx);
        end
        return res;
    endfunction

    // Winner search: lowest eligible at or above ptr, otherwise wrap to the lowest overall
    always_comb begin
        eligible_s = bus.req & ~done_r;
        hi_mask_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_mask_s[i] = (4'(i) >= ptr_r);
        end
        pick_hi_s  = lowest_set(eligible_s & hi_mask_s);
        pick_lo_s  = lowest_set(eligible_s);
        found_s    = pick_lo_s[4];
        winner_s   = pick_hi_s[4] ? pick_hi_s[3:0] : pick_lo_s[3:0];
        ptr_nxt_s  = (winner_s == LAST_IDX) ? 4'd0 : winner_s + 4'd1;
        wait_nxt_s = wait_cnt_r + CNT_W'(1);
    end

    // Select the winner's transfer fields
    always_comb begin
        sel_write_s = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_write_s = (4'(i) == winner_s) ? bus.req_write[i] : sel_write_s;
            sel_addr_s  = (4'(i) == winner_s) ? bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : sel_addr_s;
            sel_wdata_s = (4'(i) == winner_s) ? bus.req_wdata[i*32 +: 32] : sel_wdata_s;
        end
    end

    // Transfer sequencer; response outputs default to zero so they pulse for one cycle
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_r    <= ST_IDLE;
            ptr_r      <= 4'd0;
            gnt_id_r   <= 4'd0;
            wait_cnt_r <= '0;
            done_r     <= '0;
            rdata_r    <= 32'd0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            psel_r     <= 1'b0;
            penable_r  <= 1'b0;
            pwrite_r   <= 1'b0;
            paddr_r    <= '0;
            pwdata_r   <= 32'd0;
        end else begin
            done_r  <= '0;
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        pwrite_r  <= sel_write_s;
                        paddr_r   <= sel_addr_s;
                        pwdata_r  <= sel_wdata_s;
                        gnt_id_r  <= winner_s;
                        ptr_r     <= ptr_nxt_s;
                        psel_r    <= 1'b1;
                        penable_r <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_r <= 1'b1;
                    state_r   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (bus.pready) begin
                        rdata_r    <= pwrite_r ? 32'd0 : bus.prdata;
                        err_r      <= bus.pslverr;
                        done_r     <= onehot(gnt_id_r);
                        psel_r     <= 1'b0;
                        penable_r  <= 1'b0;
                        busy_r     <= 1'b0;
                        wait_cnt_r <= '0;
                        state_r    <= ST_IDLE;
                    end else if ((TIMEOUT != 0) && (wait_nxt_s == TIMEOUT_VAL)) begin
                        err_r      <= 1'b1;
                        done_r     <= onehot(gnt_id_r);
                        psel_r     <= 1'b0;
                        penable_r  <= 1'b0;
                        busy_r     <= 1'b0;
                        wait_cnt_r <= '0;
                        state_r    <= ST_IDLE;
                    end else begin
                        wait_cnt_r <= wait_nxt_s;
                    end
                end
                default: begin
                    psel_r     <= 1'b0;
                    penable_r  <= 1'b0;
                    busy_r     <= 1'b0;
                    wait_cnt_r <= '0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.done    = done_r;
    assign bus.rdata   = rdata_r;
    assign bus.err     = err_r;
    assign bus.busy    = busy_r;
    assign bus.gnt_id  = gnt_id_r;
    assign bus.psel    = psel_r;
    assign bus.penable = penable_r;
    assign bus.pwrite  = pwrite_r;
    assign bus.paddr   = paddr_r;
    assign bus.pwdata  = pwdata_r;
endmodule
